// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and line levels.
// Used by both the transmit and receive paths.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   // A 1-bit word still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data latch and LSB-first bit selector for the UART transmitter.
// ser_done flags the last data bit so the FSM can leave DATA.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  clr,
   input  logic                  adv,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  ser_bit,
   output logic                  ser_done
);

   localparam int unsigned CntW = cnt_width(DATA_WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

   logic [CntW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         word <= '0;
         cnt  <= '0;
      end else begin
         if (load) begin
            word <= data_in;
         end
         if (clr) begin
            cnt <= '0;
         end else if (adv && !ser_done) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign ser_bit  = word[cnt];
   assign ser_done = (cnt == LastCnt);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// One clock per bit; tx_out and busy are registered and follow the FSM by one cycle.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  uart_tx_clk,
   input  logic                  uart_tx_rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);

   uart_state_e           state;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  par_bit;
   logic [DATA_WIDTH-1:0] word;
   logic                  ser_bit;
   logic                  ser_done;
   logic                  load;

   assign load = (state == StIdle) && data_valid;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_serializer (
      .clk      (uart_tx_clk),
      .rst      (uart_tx_rst),
      .load     (load),
      .data_in  (p_data),
      .clr      (state == StStart),
      .adv      (state == StData),
      .word     (word),
      .ser_bit  (ser_bit),
      .ser_done (ser_done)
   );

   always_ff @(posedge uart_tx_clk) begin
      if (!uart_tx_rst) begin
         state     <= StIdle;
         tx_out    <= IDLE_LVL;
         busy      <= 1'b0;
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
         par_bit   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               tx_out <= IDLE_LVL;
               busy   <= 1'b0;
               if (data_valid) begin
                  par_en_q  <= par_en;
                  par_typ_q <= par_typ;
                  state     <= StStart;
               end
            end
            StStart: begin
               tx_out  <= START_LVL;
               busy    <= 1'b1;
               // Word is latched by now, so parity never sees live p_data.
               par_bit <= (^word) ^ (par_typ_q == PAR_ODD);
               state   <= StData;
            end
            StData: begin
               tx_out <= ser_bit;
               busy   <= 1'b1;
               if (ser_done) begin
                  state <= par_en_q ? StParity : StStop;
               end
            end
            StParity: begin
               tx_out <= par_bit;
               busy   <= 1'b1;
               state  <= StStop;
            end
            StStop: begin
               tx_out <= STOP_LVL;
               busy   <= 1'b1;
               state  <= StIdle;
            end
            default: begin
               tx_out <= IDLE_LVL;
               busy   <= 1'b0;
               state  <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-list model checked every cycle, plus literal frame checks.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       dv8, pe8, pt8, dv5, pe5, pt5;
   logic [7:0] pd8;
   logic [4:0] pd5;
   logic       tx8, busy8, tx5, busy5;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   uart_tx #(.DATA_WIDTH(8)) dut8 (
      .uart_tx_clk (clk),
      .uart_tx_rst (rst),
      .p_data      (pd8),
      .data_valid  (dv8),
      .par_en      (pe8),
      .par_typ     (pt8),
      .tx_out      (tx8),
      .busy        (busy8)
   );

   uart_tx #(.DATA_WIDTH(5)) dut5 (
      .uart_tx_clk (clk),
      .uart_tx_rst (rst),
      .p_data      (pd5),
      .data_valid  (dv5),
      .par_en      (pe5),
      .par_typ     (pt5),
      .tx_out      (tx5),
      .busy        (busy5)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole frame as a line sequence, bit i = line level in the i-th bit period.
   function automatic logic [15:0] frame_bits(input int w, input logic [15:0] d,
                                              input logic pe, input logic pt);
      logic [15:0] f;
      logic        p;
      f = '0;
      p = pt;
      for (int i = 0; i < w; i++) begin
         f[i+1] = d[i];
         p      = p ^ d[i];
      end
      if (pe) begin
         f[w+1] = p;
         f[w+2] = 1'b1;
      end else begin
         f[w+1] = 1'b1;
      end
      return f;
   endfunction

   function automatic int frame_len(input int w, input logic pe);
      return w + 2 + (pe ? 1 : 0);
   endfunction

   // Model: once idle, an accepted request plays its frame out over the following cycles.
   logic [15:0] fb8, fb5;
   logic [3:0]  pos8, pos5;
   int          rem8, rem5;
   logic        e_tx8, e_busy8, e_tx5, e_busy5;

   always @(posedge clk) begin
      if (!rst) begin
         rem8 <= 0; e_tx8 <= 1'b1; e_busy8 <= 1'b0;
      end else if (rem8 == 0) begin
         e_tx8 <= 1'b1; e_busy8 <= 1'b0;
         if (dv8) begin
            fb8  <= frame_bits(8, {8'h00, pd8}, pe8, pt8);
            rem8 <= frame_len(8, pe8);
            pos8 <= 4'd0;
         end
      end else begin
         e_tx8 <= fb8[pos8]; e_busy8 <= 1'b1; pos8 <= pos8 + 4'd1; rem8 <= rem8 - 1;
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         rem5 <= 0; e_tx5 <= 1'b1; e_busy5 <= 1'b0;
      end else if (rem5 == 0) begin
         e_tx5 <= 1'b1; e_busy5 <= 1'b0;
         if (dv5) begin
            fb5  <= frame_bits(5, {11'h000, pd5}, pe5, pt5);
            rem5 <= frame_len(5, pe5);
            pos5 <= 4'd0;
         end
      end else begin
         e_tx5 <= fb5[pos5]; e_busy5 <= 1'b1; pos5 <= pos5 + 4'd1; rem5 <= rem5 - 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_tx8", {31'd0, tx8}, {31'd0, e_tx8});
         chk("model_busy8", {31'd0, busy8}, {31'd0, e_busy8});
         chk("model_tx5", {31'd0, tx5}, {31'd0, e_tx5});
         chk("model_busy5", {31'd0, busy5}, {31'd0, e_busy5});
      end
   end

   task automatic send8(input logic [7:0] d, input logic pe, input logic pt);
      @(negedge clk);
      dv8 = 1'b1; pd8 = d; pe8 = pe; pt8 = pt;
      @(negedge clk);
      dv8 = 1'b0; pd8 = 8'($urandom); pe8 = 1'($urandom); pt8 = 1'($urandom);
   endtask

   task automatic cap8(input int n, output logic [15:0] line, output int bc);
      line = '0;
      bc   = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         line[i] = tx8;
         bc += int'(busy8);
      end
   endtask

   logic [15:0] line;
   int          bc;
   logic        la [0:22];
   logic        lb [0:22];
   logic [9:0]  f1, f2;

   initial begin
      rst = 1'b0; dv8 = 1'b1; pd8 = 8'h5A; pe8 = 1'b0; pt8 = 1'b0;
      dv5 = 1'b1; pd5 = 5'h1F; pe5 = 1'b0; pt5 = 1'b0;

      chk("pin_a5", {16'd0, frame_bits(8, 16'h00A5, 1'b0, 1'b0)}, 32'h34A);
      chk("pin_07_even", {16'd0, frame_bits(8, 16'h0007, 1'b1, 1'b0)}, 32'h60E);
      chk("pin_07_odd", {16'd0, frame_bits(8, 16'h0007, 1'b1, 1'b1)}, 32'h40E);
      chk("pin_w5", {16'd0, frame_bits(5, 16'h0013, 1'b1, 1'b1)}, 32'hA6);

      // Reset held 3 cycles with data_valid high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_en = 1'b1;
         chk("rst_tx", {31'd0, tx8}, 32'd1);
         chk("rst_busy", {31'd0, busy8}, 32'd0);
      end
      rst = 1'b1; dv8 = 1'b0; dv5 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_no_frame", {30'd0, busy8, busy5}, 32'd0);

      send8(8'hA5, 1'b0, 1'b0);
      cap8(10, line, bc);
      chk("a5_line", {16'd0, line}, 32'h34A);
      chk("a5_busy_cycles", bc, 10);
      @(negedge clk);
      chk("a5_busy_low", {31'd0, busy8}, 32'd0);
      repeat (2) @(negedge clk);

      send8(8'h07, 1'b1, 1'b0);
      cap8(11, line, bc);
      chk("07_even_line", {16'd0, line}, 32'h60E);
      chk("07_even_busy", bc, 11);
      repeat (3) @(negedge clk);

      send8(8'h07, 1'b1, 1'b1);
      cap8(11, line, bc);
      chk("07_odd_line", {16'd0, line}, 32'h40E);
      repeat (3) @(negedge clk);

      // data_valid held, p_data changing every cycle
      @(negedge clk);
      dv8 = 1'b1; pd8 = 8'h3C; pe8 = 1'b0; pt8 = 1'b0;
      for (int i = 0; i <= 22; i++) begin
         @(negedge clk);
         la[i] = tx8;
         lb[i] = busy8;
         pd8   = 8'h3C + 8'(i + 1);
      end
      dv8 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         f1[i] = la[i+1];
         f2[i] = la[i+12];
      end
      chk("hold_frame1", {22'd0, f1}, {22'd0, 1'b1, 8'h3C, 1'b0});
      chk("hold_gap", {30'd0, la[11], lb[11]}, 32'd2);
      chk("hold_frame2", {22'd0, f2}, {22'd0, 1'b1, 8'h47, 1'b0});
      repeat (15) @(negedge clk);

      // Reset during data bit 4 of 8'hFF
      send8(8'hFF, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      chk("mid_bit4", {30'd0, tx8, busy8}, 32'd3);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_abort", {30'd0, tx8, busy8}, 32'd2);
      rst = 1'b1;
      @(negedge clk);
      send8(8'h5A, 1'b1, 1'b0);
      cap8(11, line, bc);
      chk("after_rst_line", {16'd0, line}, 32'h4B4);
      chk("after_rst_busy", bc, 11);
      repeat (3) @(negedge clk);

      // DATA_WIDTH=5 instance
      @(negedge clk);
      dv5 = 1'b1; pd5 = 5'h13; pe5 = 1'b1; pt5 = 1'b1;
      @(negedge clk);
      dv5 = 1'b0; pd5 = 5'h0A; pe5 = 1'b0; pt5 = 1'b0;
      line = '0;
      bc   = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         line[i] = tx5;
         bc += int'(busy5);
      end
      chk("w5_line", {16'd0, line}, 32'hA6);
      chk("w5_busy", bc, 8);
      @(negedge clk);
      chk("w5_busy_low", {31'd0, busy5}, 32'd0);
      repeat (3) @(negedge clk);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
